instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage of the RISC-V pipeline. Owns the program counter and drives the synchronous instruction memory, whose read data is registered with one cycle of latency and which writes whenever `re` is low. It delivers `{pc, instr}` pairs to decode over a valid/ready handshake, buffering up to two of them so throughput holds under backpressure. It also handles control-flow redirects from execute, and owns a boot-load port that writes program words into instruction memory.

## Interface
- XLEN, 32: PC and instruction width (`INSTRUCTION_WIDTH`).
- DEPTH, 1024: instruction memory depth in words (`INSTRUCTION_DEPTH`); ADDR_W = $clog2(DEPTH).
- RESET_PC, 0: PC after reset and after a boot load.
- clk  in  1  clock; all state updates on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- imem_addr  out  ADDR_W  word address to instruction memory.
- imem_re  out  1  read enable; low only while writing a load word.
- imem_wdata  out  XLEN  write data to instruction memory.
- imem_rdata  in  XLEN  registered read data (address of previous cycle).
- load_en  in  1  boot-load write strobe; fetch is suspended while high.
- load_addr  in  ADDR_W  boot-load word address.
- load_data  in  XLEN  boot-load word.
- redirect_valid  in  1  branch/jump taken in execute.
- redirect_pc  in  XLEN  target PC; bits [1:0] ignored.
- id_valid  out  1  `id_instr`/`id_pc` valid for decode.
- id_ready  in  1  decode accepts; handshake when both high.
- id_instr  out  XLEN  fetched instruction.
- id_pc  out  XLEN  PC of `id_instr`.

## Operation
**State machine**
- States are RUN and LOAD.
- Reset enters RUN.
- Any cycle with load_en=1 moves to LOAD.
- In LOAD, the first cycle with load_en=0 returns to RUN with pc=RESET_PC.

**Memory port**
- `imem_re` = !load_en.
- `imem_addr` = load_en ? load_addr : pc[ADDR_W+1:2].
- `imem_wdata` = load_en ? load_data : 0.
- `imem_re` must never be low outside load cycles, or the memory writes; this includes stall and flush cycles.

**Request tracking**
- A request issues in RUN when the issue condition holds; the issue condition is "no flush, and (queue occupancy + in-flight − handshake this cycle) < 2".
- On issue: inflight<=1, inflight_pc<=pc, pc<=pc+4 (mod 2^XLEN).
- When no request issues, the memory re-reads the same address harmlessly.

**Queue**
- Two entries: an output register plus a skid register, in FIFO order.
- An in-flight response is written next cycle into the first free entry, taking `imem_rdata` and `inflight_pc`.
- On a handshake, the skid entry moves to the output register.

**Flush** (redirect_valid=1, or entry to LOAD)
- Clears the queue, kills the in-flight response (its data is discarded), and clears id_valid next cycle.
- On redirect, pc<={redirect_pc[XLEN-1:2],2'b00}; the flush cycle issues no request.
- A handshake in the flush cycle completes normally; only entries not yet accepted are dropped.

**Priority and ordering**
- Priority: load_en > redirect_valid > sequential.
- Address wrap: imem_addr wraps to 0 past DEPTH-1 because only pc[ADDR_W+1:2] is used; the pc itself wraps at 2^XLEN.
- `id_instr`/`id_pc` hold steady while id_valid && !id_ready.

## Timing
- Reset values:
  - pc=RESET_PC, state RUN, inflight=0, queue empty.
  - id_valid=0, id_instr=0, id_pc=0.
  - imem_re=1, imem_wdata=0, imem_addr=RESET_PC[ADDR_W+1:2].
- Latency:
  - Request issued in cycle N.
  - imem_rdata valid in N+1.
  - id_valid high in N+2.
- The first instruction after reset release, redirect, or load exit appears 2 cycles after the first issue cycle.
- With id_ready held high, throughput is 1 instruction/cycle and no bubbles are inserted.
- With id_ready low, at most one more instruction lands in the skid entry and issue stops; the buffered pair is delivered back-to-back once id_ready rises.
- Redirect penalty: target issued the cycle after redirect_valid, so its id_valid appears 3 cycles after the redirect cycle.
- rstn assertion mid-operation clears everything immediately and asynchronously; no partial output survives.

## Test plan
1. Preload words 0..3 with 0x11,0x22,0x33,0x44 via load_en, then release it with id_ready=1 → pc RESET_PC=0; id_valid rises 2 cycles after the first issue and pairs (0,0x11),(4,0x22),(8,0x33),(12,0x44) arrive on consecutive cycles.
2. Backpressure: drop id_ready for 5 cycles mid-stream → output holds (pc 8), at most 2 entries buffered, no loss or duplication; pc 12 follows pc 8 immediately when id_ready returns.
3. Redirect: redirect_valid with redirect_pc=0x43 while an entry is waiting → stale entries dropped, next delivered pair is (0x40, word 16), 3 cycles after the redirect.
4. Redirect in the same cycle as a handshake → the accepted entry is counted once; no younger sequential instruction appears afterwards.
5. Wrap-around: DEPTH=16, run past pc 0x3C → next imem_addr=0; id_pc=0x40 carries word 0.
6. Assert rstn low mid-stream with buffer full → id_valid=0 and pc=RESET_PC immediately; imem_re=1 throughout the stall and flush cycles, so no memory writes.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage. Owns the PC, drives the synchronous instruction memory and
// the boot-load write port, and hands {pc, instr} pairs to decode through a two-entry queue.
module instruction_fetch_unit #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 1024,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    localparam int              ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_re,
    output logic [XLEN-1:0]   imem_wdata,
    input  logic [XLEN-1:0]   imem_rdata,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [XLEN-1:0]   load_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [XLEN-1:0]   id_instr,
    output logic [XLEN-1:0]   id_pc
);

    typedef enum logic {RUN, LOAD} state_e;

    state_e            state_q;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              inflight_q, inflight_d;
    logic [XLEN-1:0]   inflightPc_q, inflightPc_d;
    logic              outValid_q, outValid_d;
    logic [XLEN-1:0]   outInstr_q, outInstr_d;
    logic [XLEN-1:0]   outPc_q, outPc_d;
    logic              skidValid_q, skidValid_d;
    logic [XLEN-1:0]   skidInstr_q, skidInstr_d;
    logic [XLEN-1:0]   skidPc_q, skidPc_d;

    logic              handshake;
    logic              flush;
    logic              issue;
    logic [1:0]        pending;
    logic              unusedRedirectLsbs;

    assign handshake = outValid_q && id_ready;
    assign flush     = load_en || redirect_valid;

    // Entries that will still occupy the queue after this cycle's handshake; a new
    // request is only allowed while a free slot is guaranteed when its data returns.
    assign pending = 2'(outValid_q) + 2'(skidValid_q) + 2'(inflight_q) - 2'(handshake);
    assign issue   = (state_q == RUN) && !flush && (pending < 2'd2);

    assign imem_re    = !load_en;
    assign imem_addr  = load_en ? load_addr : pc_q[ADDR_W+1:2];
    assign imem_wdata = load_en ? load_data : '0;

    assign id_valid = outValid_q;
    assign id_instr = outInstr_q;
    assign id_pc    = outPc_q;

    assign unusedRedirectLsbs = ^redirect_pc[1:0];

    always_comb begin
        pc_d         = pc_q;
        inflight_d   = 1'b0;
        inflightPc_d = inflightPc_q;
        outValid_d   = outValid_q;
        outInstr_d   = outInstr_q;
        outPc_d      = outPc_q;
        skidValid_d  = skidValid_q;
        skidInstr_d  = skidInstr_q;
        skidPc_d     = skidPc_q;

        if (flush) begin
            outValid_d  = 1'b0;
            skidValid_d = 1'b0;
        end else begin
            if (handshake) begin
                outValid_d  = skidValid_q;
                outInstr_d  = skidInstr_q;
                outPc_d     = skidPc_q;
                skidValid_d = 1'b0;
            end
            // Returning data fills the oldest free slot so FIFO order is preserved.
            if (inflight_q) begin
                if (!outValid_d) begin
                    outValid_d = 1'b1;
                    outInstr_d = imem_rdata;
                    outPc_d    = inflightPc_q;
                end else begin
                    skidValid_d = 1'b1;
                    skidInstr_d = imem_rdata;
                    skidPc_d    = inflightPc_q;
                end
            end
        end

        if (load_en) begin
            pc_d = pc_q;
        end else if (state_q == LOAD) begin
            pc_d = RESET_PC;
        end else if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (issue) begin
            pc_d = pc_q + XLEN'(4);
        end

        if (issue) begin
            inflight_d   = 1'b1;
            inflightPc_d = pc_q;
        end
    end

    // Boot-load mode is entered on any load strobe and left on the first idle cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
        end else if (load_en) begin
            state_q <= LOAD;
        end else begin
            state_q <= RUN;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q         <= RESET_PC;
            inflight_q   <= 1'b0;
            inflightPc_q <= '0;
            outValid_q   <= 1'b0;
            outInstr_q   <= '0;
            outPc_q      <= '0;
            skidValid_q  <= 1'b0;
            skidInstr_q  <= '0;
            skidPc_q     <= '0;
        end else begin
            pc_q         <= pc_d;
            inflight_q   <= inflight_d;
            inflightPc_q <= inflightPc_d;
            outValid_q   <= outValid_d;
            outInstr_q   <= outInstr_d;
            outPc_q      <= outPc_d;
            skidValid_q  <= skidValid_d;
            skidInstr_q  <= skidInstr_d;
            skidPc_q     <= skidPc_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a reference program image predicts the
// {pc, instr} stream, and a negedge monitor checks handshakes, holds and latencies.
module tb_instruction_fetch_unit;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } pair_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_re;
    logic [XLEN-1:0]   imem_wdata;
    logic [XLEN-1:0]   imem_rdata;
    logic              load_en = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [XLEN-1:0]   load_data = '0;
    logic              redirect_valid = 1'b0;
    logic [XLEN-1:0]   redirect_pc = '0;
    logic              id_valid;
    logic              id_ready = 1'b0;
    logic [XLEN-1:0]   id_instr;
    logic [XLEN-1:0]   id_pc;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;
    int hsCount = 0;

    pair_t           expQ[$];
    logic [XLEN-1:0] refMem [DEPTH];
    logic [XLEN-1:0] nextPc = '0;
    logic            prevLdDriven = 1'b0;

    logic [XLEN-1:0] imemArray [DEPTH];

    instruction_fetch_unit #(
        .XLEN(XLEN),
        .DEPTH(DEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .imem_addr(imem_addr),
        .imem_re(imem_re),
        .imem_wdata(imem_wdata),
        .imem_rdata(imem_rdata),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_instr(id_instr),
        .id_pc(id_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt++;

    // Synchronous instruction memory: registered read, writes whenever re is low.
    always @(posedge clk) begin
        if (!imem_re) imemArray[imem_addr] <= imem_wdata;
        imem_rdata <= imemArray[imem_addr];
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic refill();
        while (expQ.size() < 8) begin
            expQ.push_back('{pc: nextPc, instr: refMem[nextPc[ADDR_W+1:2]]});
            nextPc = nextPc + 32'd4;
        end
    endtask

    task automatic restartStream(input logic [XLEN-1:0] startPc);
        expQ.delete();
        nextPc = startPc;
        refill();
    endtask

    // One clock cycle of stimulus; expectations are updated after the monitor has
    // seen this cycle, so a handshake coinciding with a flush still counts.
    task automatic applyStimulus(input logic ld, input logic [ADDR_W-1:0] la, input logic [XLEN-1:0] lData,
                                 input logic rv, input logic [XLEN-1:0] rpc, input logic rdy);
        load_en        = ld;
        load_addr      = la;
        load_data      = lData;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        if (ld) refMem[la] = lData;
        @(negedge clk);
        #1;
        if (ld) begin
            expQ.delete();
        end else begin
            if (prevLdDriven) restartStream(RESET_PC);
            else if (rv) restartStream({rpc[XLEN-1:2], 2'b00});
            refill();
        end
        prevLdDriven = ld;
        @(posedge clk);
        #1;
    endtask

    logic            prevRstn = 1'b0;
    logic            prevValid = 1'b0;
    logic            prevReady = 1'b0;
    logic            prevFlush = 1'b0;
    logic            prevLoad = 1'b0;
    logic [XLEN-1:0] prevPc = '0;
    logic [XLEN-1:0] prevInstr = '0;
    logic            awaiting = 1'b0;
    int              startCycle = 0;
    int              expLat = 0;
    pair_t           monExp;

    always @(negedge clk) begin
        if (!rstn) begin
            prevRstn  = 1'b0;
            prevValid = 1'b0;
            prevFlush = 1'b0;
            prevLoad  = 1'b0;
            awaiting  = 1'b0;
        end else begin
            if (!prevRstn) begin
                awaiting = 1'b1; startCycle = cycleCnt; expLat = 2;
            end else if (prevLoad && !load_en) begin
                awaiting = 1'b1; startCycle = cycleCnt; expLat = 3;
            end
            if (load_en) begin
                awaiting = 1'b0;
            end else if (redirect_valid) begin
                awaiting = 1'b1; startCycle = cycleCnt; expLat = 3;
            end else if (awaiting && id_valid) begin
                checkOutput("first_valid_latency", 64'(cycleCnt - startCycle), 64'(expLat));
                awaiting = 1'b0;
            end else if (awaiting && (cycleCnt - startCycle) > 8) begin
                checkOutput("first_valid_timeout", 64'(cycleCnt - startCycle), 64'(expLat));
                awaiting = 1'b0;
            end

            if (prevValid && !prevReady && !prevFlush) begin
                checkOutput("hold_valid", id_valid, 1'b1);
                checkOutput("hold_pc", id_pc, prevPc);
                checkOutput("hold_instr", id_instr, prevInstr);
            end

            if (id_valid && id_ready) begin
                hsCount++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_handshake actual pc=%0h required=none", id_pc);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("id_pc", id_pc, monExp.pc);
                    checkOutput("id_instr", id_instr, monExp.instr);
                end
            end

            checkOutput("imem_re", imem_re, !load_en);
            if (load_en) begin
                checkOutput("imem_addr_load", imem_addr, load_addr);
                checkOutput("imem_wdata_load", imem_wdata, load_data);
            end else begin
                checkOutput("imem_wdata_idle", imem_wdata, '0);
            end

            prevRstn  = 1'b1;
            prevValid = id_valid;
            prevReady = id_ready;
            prevFlush = load_en || redirect_valid;
            prevLoad  = load_en;
            prevPc    = id_pc;
            prevInstr = id_instr;
        end
    end

    task automatic resetMidStream();
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("rst_id_valid", id_valid, 1'b0);
        checkOutput("rst_id_pc", id_pc, '0);
        checkOutput("rst_id_instr", id_instr, '0);
        checkOutput("rst_imem_re", imem_re, 1'b1);
        checkOutput("rst_imem_addr", imem_addr, RESET_PC[ADDR_W+1:2]);
        expQ.delete();
        prevLdDriven = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        restartStream(RESET_PC);
    endtask

    initial begin
        int hsBefore;
        int cool;
        int r;
        int n;
        logic [ADDR_W-1:0] addrA;

        repeat (2) @(negedge clk);
        checkOutput("reset_id_valid", id_valid, 1'b0);
        checkOutput("reset_id_pc", id_pc, '0);
        checkOutput("reset_id_instr", id_instr, '0);
        checkOutput("reset_imem_re", imem_re, 1'b1);
        checkOutput("reset_imem_wdata", imem_wdata, '0);
        checkOutput("reset_imem_addr", imem_addr, RESET_PC[ADDR_W+1:2]);

        // Boot-load the whole image, first four words with a known program.
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, ADDR_W'(i), (i < 4) ? 32'h11 * (i + 1) : $urandom, 1'b0, '0, 1'b0);
        end
        hsBefore = hsCount;
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
        repeat (6) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
        checkOutput("load_exit_throughput", 64'(hsCount - hsBefore), 64'd4);

        // Backpressure: issue must stop and the buffered pair drain back-to-back.
        addrA = '0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
            if (i == 2) addrA = imem_addr;
        end
        checkOutput("stall_issue_stopped", imem_addr, addrA);
        hsBefore = hsCount;
        repeat (2) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
        checkOutput("stall_drain_pair", 64'(hsCount - hsBefore), 64'd2);

        // Redirect with an entry waiting, then redirect coinciding with a handshake.
        repeat (2) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 32'h43, 1'b0);
        repeat (6) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
        hsBefore = hsCount;
        applyStimulus(1'b0, '0, '0, 1'b1, 32'h20, 1'b1);
        checkOutput("redirect_with_handshake", 64'(hsCount - hsBefore), 64'd1);
        repeat (6) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);

        // Word address wraps past DEPTH-1.
        applyStimulus(1'b0, '0, '0, 1'b1, 32'h3C, 1'b1);
        checkOutput("wrap_addr_last", imem_addr, 4'd15);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);
        checkOutput("wrap_addr_zero", imem_addr, 4'd0);
        repeat (6) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);

        // Asynchronous reset with the queue full.
        repeat (4) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b0);
        resetMidStream();
        repeat (8) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);

        cool = 0;
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 99);
            if (cool > 0) cool--;
            if (cool == 0 && r < 2) begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) begin
                    applyStimulus(1'b1, ADDR_W'($urandom), $urandom, 1'b0, '0, 1'($urandom));
                end
                cool = 6;
            end else if (cool == 0 && r < 10) begin
                applyStimulus(1'b0, '0, '0, 1'b1, $urandom, ($urandom_range(0, 3) != 0));
                cool = 5;
            end else begin
                applyStimulus(1'b0, '0, '0, 1'b0, '0, ($urandom_range(0, 3) != 0));
            end
        end
        repeat (10) applyStimulus(1'b0, '0, '0, 1'b0, '0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
